ones_position_streamer: RTL and testbench

//  Downstream consumer of the set-bit compactor (positions[], count). Latches one compacted

---
 rtl/ones_position_streamer_pkg.sv | 18 +
 rtl/ones_position_streamer_window_mux.sv | 39 +++
 rtl/ones_position_streamer.sv | 98 +++++++++
 tb/tb_ones_position_streamer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ones_position_streamer_pkg.sv
// Shared types and helpers for the compacted-position streamer.
package ones_stream_pkg;

    // IDLE: no list held, ready for a new one. STREAM: list held, beats being emitted.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Beats a list of 'count' entries occupies: ceil(count/lanes), but never fewer than one,
    // because an empty list still produces a single terminating beat.
    function automatic int unsigned beats(input int unsigned count, input int unsigned lanes);
        int unsigned b;
        b = (count + lanes - 1) / lanes;
        return (b == 0) ? 1 : b;
    endfunction

endpackage

// File: rtl/ones_position_streamer_window_mux.sv
// Picks LANES consecutive entries out of the latched position buffer starting at rd_ptr,
// and decodes the per-lane valid mask and the last-beat flag from rd_ptr and count.
module pos_window_mux #(
    parameter int N     = 256,
    parameter int LOGN  = 8,
    parameter int LANES = 4
) (
    input  logic [N*LOGN-1:0]     buf_flat,
    input  logic [LOGN:0]         rd_ptr,
    input  logic [LOGN:0]         count,
    input  logic                  enable,
    output logic [LANES*LOGN-1:0] positions,
    output logic [LANES-1:0]      mask,
    output logic                  last
);

    // One extra bit of headroom so rd_ptr + lane never wraps before the compare.
    logic [LOGN+1:0] idx;

    // Lane selection: lanes past the end of the list are masked and forced to position 0.
    always_comb begin
        positions = '0;
        mask      = '0;
        idx       = '0;
        for (int l = 0; l < LANES; l++) begin
            idx = {1'b0, rd_ptr} + (LOGN+2)'(l);
            if (enable && (idx < {1'b0, count})) begin
                mask[l] = 1'b1;
                positions[l*LOGN +: LOGN] = buf_flat[int'(idx[LOGN-1:0])*LOGN +: LOGN];
            end
        end
    end

    // Last beat once this window reaches or passes the end of the list (covers count == 0).
    always_comb begin
        last = enable && (({1'b0, rd_ptr} + (LOGN+2)'(LANES)) >= {1'b0, count});
    end

endmodule

// File: rtl/ones_position_streamer.sv
// Latches one compacted position list per input handshake and streams it out LANES
// positions per beat. Handshakes on both sides are valid/ready: a transfer happens in
// any cycle where valid && ready are both high at the clock edge; a raised valid is
// held, with its payload stable, until that transfer occurs.
module ones_position_streamer
    import ones_stream_pkg::*;
#(
    parameter int N     = 256,
    parameter int LOGN  = (N > 1) ? $clog2(N) : 1,
    parameter int LANES = 4,
    parameter int TAG_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*LOGN-1:0]     in_positions,
    input  logic [LOGN:0]         in_count,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*LOGN-1:0] out_positions,
    output logic [LANES-1:0]      out_mask,
    output logic                  out_last,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  busy
);

    state_t              state_q, state_d;
    logic [LOGN:0]       rd_ptr_q;
    logic [LOGN:0]       count_q;
    logic [N*LOGN-1:0]   pos_buf_q;
    logic [TAG_W-1:0]    tag_q;
    logic                in_hs;
    logic                out_hs;

    // Output beat is a pure decode of registered state, so no in_* reaches out_*.
    pos_window_mux #(
        .N     (N),
        .LOGN  (LOGN),
        .LANES (LANES)
    ) u_window (
        .buf_flat  (pos_buf_q),
        .rd_ptr    (rd_ptr_q),
        .count     (count_q),
        .enable    (state_q == STREAM),
        .positions (out_positions),
        .mask      (out_mask),
        .last      (out_last)
    );

    assign out_valid = (state_q == STREAM);
    assign busy      = (state_q == STREAM);
    assign out_tag   = tag_q;
    assign out_hs    = out_valid && out_ready;

    // Accept when idle, or in the cycle the final beat leaves so lists run without a bubble.
    // out_ready -> in_ready is the only combinational path through the block.
    always_comb begin
        in_ready = !reset && ((state_q == IDLE) || (out_hs && out_last));
        in_hs    = in_valid && in_ready;
    end

    // Next state: a new list always wins over returning to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_hs) state_d = STREAM;
            STREAM:  begin
                if (in_hs)                  state_d = STREAM;
                else if (out_hs && out_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, list buffer and read pointer; reset discards any list in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pos_buf_q <= '0;
            tag_q     <= '0;
        end else begin
            state_q <= state_d;
            if (in_hs) begin
                pos_buf_q <= in_positions;
                count_q   <= in_count;
                tag_q     <= in_tag;
                rd_ptr_q  <= '0;
            end else if (out_hs && !out_last) begin
                rd_ptr_q  <= rd_ptr_q + (LOGN+1)'(LANES);
            end
        end
    end

endmodule

// File: tb/tb_ones_position_streamer.sv
// Bench for ones_position_streamer at N=16, LANES=4, TAG_W=8.
module tb_ones_position_streamer;

    localparam int N     = 16;
    localparam int LOGN  = 4;
    localparam int LANES = 4;
    localparam int TAG_W = 8;
    localparam int PW    = LANES*LOGN;
    localparam int BW    = 1 + LANES + TAG_W + PW;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [N*LOGN-1:0] in_positions;
    logic [LOGN:0]     in_count;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [PW-1:0]     out_positions;
    logic [LANES-1:0]  out_mask;
    logic              out_last;
    logic [TAG_W-1:0]  out_tag;
    logic              busy;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [BW-1:0] exp_q[$];

    typedef struct {
        int                count;
        logic [N*LOGN-1:0] pos;
        logic [TAG_W-1:0]  tag;
        int                nbeats;
        logic [1:0][PW-1:0] epos;
        logic [1:0][3:0]   emask;
        logic [1:0]        elast;
    } vec_t;

    vec_t vec[3];

    ones_position_streamer #(
        .N     (N),
        .LOGN  (LOGN),
        .LANES (LANES),
        .TAG_W (TAG_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_positions  (in_positions),
        .in_count      (in_count),
        .in_tag        (in_tag),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_positions (out_positions),
        .out_mask      (out_mask),
        .out_last      (out_last),
        .out_tag       (out_tag),
        .busy          (busy)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] cur_beat();
        return {out_last, out_mask, out_tag, out_positions};
    endfunction

    function automatic logic [BW-1:0] mk_beat(input logic last, input logic [3:0] m,
                                              input logic [TAG_W-1:0] t, input logic [PW-1:0] p);
        return {last, m, t, p};
    endfunction

    // Reference model: expand a whole list into its expected beats from the list semantics.
    task automatic push_list(input int cnt, input logic [N*LOGN-1:0] pos, input logic [TAG_W-1:0] tag);
        int nb;
        logic [PW-1:0] p;
        logic [3:0] m;
        nb = (cnt == 0) ? 1 : (cnt + LANES - 1) / LANES;
        for (int b = 0; b < nb; b++) begin
            p = '0;
            m = '0;
            for (int l = 0; l < LANES; l++) begin
                int i;
                i = b*LANES + l;
                if (i < cnt) begin
                    m[l] = 1'b1;
                    p[l*LOGN +: LOGN] = pos[i*LOGN +: LOGN];
                end
            end
            exp_q.push_back(mk_beat(b == nb-1, m, tag, p));
        end
    endtask

    task automatic drive_list(input int cnt, input logic [N*LOGN-1:0] pos, input logic [TAG_W-1:0] tag);
        in_valid     = 1'b1;
        in_count     = (LOGN+1)'(cnt);
        in_positions = pos;
        in_tag       = tag;
    endtask

    initial begin
        logic [BW:0] held_beat;
        logic        held;
        logic        accepted;
        int          lists_sent;

        vec[0] = '{0, 64'h1234_5678_9ABC_DEF0, 8'h11, 1, {16'h0000, 16'h0000}, {4'h0, 4'h0}, 2'b01};
        vec[1] = '{4, 64'hFFFF_FFFF_FFFF_FA50, 8'h22, 1, {16'h0000, 16'hFA50}, {4'h0, 4'hF}, 2'b01};
        vec[2] = '{6, 64'hFFFF_EEEE_5A98_7321, 8'h33, 2, {16'h0098, 16'h7321}, {4'h3, 4'hF}, 2'b10};

        // Reset
        reset = 1'b1; in_valid = 1'b0; in_positions = '0; in_count = '0; in_tag = '0; out_ready = 1'b0;
        tick(); tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_beat", 64'(cur_beat()), 64'd0);
        reset = 1'b0;
        #1;
        check("idle_in_ready", 64'(in_ready), 64'd1);
        tick();

        // Table-driven single lists (tests 1-3)
        for (int v = 0; v < 3; v++) begin
            drive_list(vec[v].count, vec[v].pos, vec[v].tag);
            out_ready = 1'b1;
            #1;
            check("vec_in_ready", 64'(in_ready), 64'd1);
            tick();
            in_valid = 1'b0;
            #1;
            for (int b = 0; b < vec[v].nbeats; b++) begin
                check("vec_valid", 64'(out_valid), 64'd1);
                check("vec_beat", 64'(cur_beat()),
                      64'(mk_beat(vec[v].elast[b], vec[v].emask[b], vec[v].tag, vec[v].epos[b])));
                if (vec[v].elast[b]) check("vec_last_in_ready", 64'(in_ready), 64'd1);
                tick();
            end
            check("vec_done", 64'({out_valid, busy}), 64'd0);
        end

        // Test 4: backpressure on beat 1 of the 6-entry list
        drive_list(vec[2].count, vec[2].pos, vec[2].tag);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        #1;
        held_beat = {out_valid, cur_beat()};
        check("bp_beat1", 64'(held_beat), 64'({1'b1, mk_beat(1'b0, 4'hF, 8'h33, 16'h7321)}));
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_hold", 64'({out_valid, cur_beat()}), 64'(held_beat));
        end
        out_ready = 1'b1;
        tick();
        check("bp_beat2", 64'({out_valid, cur_beat()}), 64'({1'b1, mk_beat(1'b1, 4'h3, 8'h33, 16'h0098)}));
        tick();
        check("bp_done", 64'(out_valid), 64'd0);

        // Test 5: back-to-back lists, second accepted on the first's last beat
        drive_list(4, 64'hFFFF_FFFF_FFFF_3210, 8'h44);
        tick();
        drive_list(16, 64'h0123_4567_89AB_CDEF, 8'h55);
        #1;
        check("b2b_first", 64'({out_valid, cur_beat()}), 64'({1'b1, mk_beat(1'b1, 4'hF, 8'h44, 16'h3210)}));
        check("b2b_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            logic [63:0] src;
            src = 64'h0123_4567_89AB_CDEF;
            check("b2b_second", 64'({out_valid, cur_beat()}),
                  64'({1'b1, mk_beat(b == 3, 4'hF, 8'h55, src[b*PW +: PW])}));
            tick();
        end
        check("b2b_done", 64'(out_valid), 64'd0);

        // Test 6: reset during beat 2 of a full list, then a fresh short list
        drive_list(16, 64'hFEDC_BA98_7654_3210, 8'h77);
        tick();
        in_valid = 1'b0;
        tick();
        check("mid_beat2", 64'(cur_beat()), 64'(mk_beat(1'b0, 4'hF, 8'h77, 16'h7654)));
        reset = 1'b1;
        #1;
        check("mid_rst_valid_busy", 64'({out_valid, busy, in_ready}), 64'd0);
        check("mid_rst_beat", 64'({out_mask, out_last, out_positions}), 64'd0);
        tick();
        reset = 1'b0;
        #1;
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        drive_list(2, 64'hFFFF_FFFF_FFFF_FFC5, 8'h66);
        tick();
        in_valid = 1'b0;
        check("post_rst_beat", 64'({out_valid, cur_beat()}), 64'({1'b1, mk_beat(1'b1, 4'h3, 8'h66, 16'h00C5)}));
        tick();
        check("post_rst_done", 64'(out_valid), 64'd0);

        // Randomized traffic against the list-level model
        exp_q.delete();
        held = 1'b0;
        held_beat = '0;
        lists_sent = 0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            accepted = 1'b0;
            if (!in_valid && lists_sent < 80 && $urandom_range(0, 2) != 0) begin
                drive_list($urandom_range(0, N), {$urandom, $urandom}, TAG_W'($urandom_range(0, 255)));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (held) check("rnd_hold", 64'({out_valid, cur_beat()}), 64'(held_beat));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("rnd_unexpected_beat", 64'(cur_beat()), 64'hFFFF_FFFF_FFFF_FFFF);
                else check("rnd_beat", 64'(cur_beat()), 64'(exp_q.pop_front()));
            end
            if (in_valid && in_ready) begin
                push_list(int'(in_count), in_positions, in_tag);
                lists_sent++;
                accepted = 1'b1;
            end
            held = out_valid && !out_ready;
            held_beat = {out_valid, cur_beat()};
            @(posedge clk);
            #1;
            if (accepted) in_valid = 1'b0;
            if (lists_sent >= 80 && exp_q.size() == 0 && !out_valid && !in_valid) break;
        end
        check("rnd_lists_sent", 64'(lists_sent), 64'd80);
        check("rnd_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
